// File: rtl/decoder_onehot_seq.sv
// Registered one-hot decoder with DIRECT (loaded select) and SCAN (dwell-timed
// round-robin) modes. Define DECODER_ACTIVE_LOW_OUT_EN for an active-low y_out.
module decoder_onehot_seq #(
  parameter int unsigned SEL_WIDTH   = 3,
  parameter int unsigned DWELL_WIDTH = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      enable_in,
  input  logic                      mode_in,
  input  logic                      load_in,
  input  logic [SEL_WIDTH-1:0]      sel_in,
  input  logic [DWELL_WIDTH-1:0]    dwell_in,
  input  logic [SEL_WIDTH-1:0]      scan_last_in,
  output logic [(2**SEL_WIDTH)-1:0] y_out,
  output logic [SEL_WIDTH-1:0]      idx_out,
  output logic                      valid_out,
  output logic                      wrap_out
);

  localparam int unsigned OUT_WIDTH = 2 ** SEL_WIDTH;

`ifdef DECODER_ACTIVE_LOW_OUT_EN
  localparam logic [OUT_WIDTH-1:0] Y_INACTIVE = '1;
`else
  localparam logic [OUT_WIDTH-1:0] Y_INACTIVE = '0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIRECT,
    ST_SCAN
  } state_t;

  state_t                 state_q, state_nxt;
  logic [SEL_WIDTH-1:0]   idx_q, idx_nxt;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_nxt;
  logic                   wrap_nxt;
  logic [OUT_WIDTH-1:0]   onehot_nxt;
  logic [OUT_WIDTH-1:0]   y_nxt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      y_out     <= Y_INACTIVE;
      valid_out <= 1'b0;
      wrap_out  <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      idx_q     <= idx_nxt;
      cnt_q     <= cnt_nxt;
      y_out     <= y_nxt;
      valid_out <= (state_nxt != ST_IDLE);
      wrap_out  <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    idx_nxt   = idx_q;
    cnt_nxt   = '0;
    wrap_nxt  = 1'b0;

    if (enable_in) begin
      state_nxt = mode_in ? ST_SCAN : ST_DIRECT;
    end

    unique case (state_nxt)
      ST_IDLE: begin
        idx_nxt = idx_q;
      end
      ST_DIRECT: begin
        if (load_in) begin
          idx_nxt = sel_in;
        end
      end
      ST_SCAN: begin
        if (state_q != ST_SCAN) begin
          idx_nxt = '0;
        end else if (cnt_q >= dwell_in) begin
          // >= keeps the position finite if dwell_in is lowered below the count
          if (idx_q >= scan_last_in) begin
            idx_nxt  = '0;
            wrap_nxt = 1'b1;
          end else begin
            idx_nxt = idx_q + SEL_WIDTH'(1);
          end
        end else begin
          cnt_nxt = cnt_q + DWELL_WIDTH'(1);
        end
      end
      default: begin
        idx_nxt = idx_q;
      end
    endcase
  end

  always_comb begin
    onehot_nxt = '0;
    y_nxt      = Y_INACTIVE;
    if (state_nxt != ST_IDLE) begin
      onehot_nxt[idx_nxt] = 1'b1;
`ifdef DECODER_ACTIVE_LOW_OUT_EN
      y_nxt = ~onehot_nxt;
`else
      y_nxt = onehot_nxt;
`endif
    end
  end

  assign idx_out = idx_q;

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Self-checking bench for decoder_onehot_seq: cycle-level reference model plus
// directed scenarios with literal expectations.
module tb_decoder_onehot_seq;

  localparam int SW = 3;
  localparam int OW = 8;
  localparam int DW = 8;

`ifdef DECODER_ACTIVE_LOW_OUT_EN
  localparam logic [OW-1:0] Y_OFF  = 8'hFF;
  localparam logic [OW-1:0] Y_SEL5 = 8'b1101_1111;
  localparam logic [OW-1:0] Y_SEL0 = 8'b1111_1110;
  localparam logic [OW-1:0] Y_SEL1 = 8'b1111_1101;
  localparam bit ACT_LOW = 1'b1;
`else
  localparam logic [OW-1:0] Y_OFF  = 8'h00;
  localparam logic [OW-1:0] Y_SEL5 = 8'b0010_0000;
  localparam logic [OW-1:0] Y_SEL0 = 8'b0000_0001;
  localparam logic [OW-1:0] Y_SEL1 = 8'b0000_0010;
  localparam bit ACT_LOW = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          enable_in = 1'b0;
  logic          mode_in = 1'b0;
  logic          load_in = 1'b0;
  logic [SW-1:0] sel_in = '0;
  logic [DW-1:0] dwell_in = '0;
  logic [SW-1:0] scan_last_in = '0;
  logic [OW-1:0] y_out;
  logic [SW-1:0] idx_out;
  logic          valid_out;
  logic          wrap_out;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  decoder_onehot_seq #(.SEL_WIDTH(SW), .DWELL_WIDTH(DW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .enable_in(enable_in),
    .mode_in(mode_in), .load_in(load_in), .sel_in(sel_in),
    .dwell_in(dwell_in), .scan_last_in(scan_last_in), .y_out(y_out),
    .idx_out(idx_out), .valid_out(valid_out), .wrap_out(wrap_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: "active" flag, current position, and how many cycles
  // the current position has been visible so far.
  bit      m_active, m_scanning, m_wrap;
  int      m_idx, m_held;

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m_active = 0; m_scanning = 0; m_wrap = 0; m_idx = 0; m_held = 0;
    end else begin
      m_wrap = 0;
      if (!enable_in) begin
        m_active = 0; m_scanning = 0;
      end else if (!mode_in) begin
        m_active = 1; m_scanning = 0;
        if (load_in) m_idx = int'(sel_in);
      end else if (!m_scanning) begin
        m_active = 1; m_scanning = 1; m_idx = 0; m_held = 1;
      end else if (m_held >= int'(dwell_in) + 1) begin
        m_held = 1;
        if (m_idx >= int'(scan_last_in)) begin
          m_idx = 0; m_wrap = 1;
        end else begin
          m_idx = m_idx + 1;
        end
      end else begin
        m_held = m_held + 1;
      end
    end
  end

  function automatic logic [OW-1:0] model_y();
    logic [OW-1:0] v;
    v = '0;
    if (m_active) v[m_idx] = 1'b1;
    return ACT_LOW ? ~v : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    if (cmp_en) begin
      check("model_y", 32'(y_out), 32'(model_y()));
      check("model_idx", 32'(idx_out), 32'(m_idx));
      check("model_valid", 32'(valid_out), 32'(m_active));
      check("model_wrap", 32'(wrap_out), 32'(m_wrap));
    end
  end

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  int exp_seq [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  int budget;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    step(); step();
    check("rst_y", 32'(y_out), 32'(Y_OFF));
    check("rst_idx", 32'(idx_out), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_wrap", 32'(wrap_out), 32'd0);
    rst_n_in = 1'b1;
    cmp_en = 1'b1;
    step();

    // Direct load of 5
    enable_in = 1; mode_in = 0; load_in = 1; sel_in = 3'd5;
    step();
    check("direct_y", 32'(y_out), 32'(Y_SEL5));
    check("direct_idx", 32'(idx_out), 32'd5);
    check("direct_valid", 32'(valid_out), 32'd1);
    load_in = 0; sel_in = 3'd2;
    step();
    check("direct_hold_idx", 32'(idx_out), 32'd5);

    // Enable drop and restore
    enable_in = 0;
    step();
    check("dis_y", 32'(y_out), 32'(Y_OFF));
    check("dis_valid", 32'(valid_out), 32'd0);
    check("dis_idx", 32'(idx_out), 32'd5);
    enable_in = 1;
    step();
    check("reen_y", 32'(y_out), 32'(Y_SEL5));

    // Scan with dwell 2, last 3
    dwell_in = 8'd2; scan_last_in = 3'd3; mode_in = 1;
    for (int i = 0; i < 13; i++) begin
      step();
      check("scan_idx", 32'(idx_out), 32'(exp_seq[i]));
      check("scan_wrap", 32'(wrap_out), (i == 12) ? 32'd1 : 32'd0);
    end

    // Restart scan, run to idx 6 with last 7, then lower limit to 2
    mode_in = 0; step();
    mode_in = 1; dwell_in = 8'd1; scan_last_in = 3'd7;
    step();
    check("rescan_idx0", 32'(idx_out), 32'd0);
    check("rescan_nowrap", 32'(wrap_out), 32'd0);
    budget = 0;
    while (idx_out != 3'd6 && budget < 40) begin
      step();
      budget++;
    end
    check("reach_idx6", 32'(idx_out), 32'd6);
    scan_last_in = 3'd2;
    step();
    check("lower_hold6", 32'(idx_out), 32'd6);
    step();
    check("lower_wrap_idx", 32'(idx_out), 32'd0);
    check("lower_wrap_pulse", 32'(wrap_out), 32'd1);
    step();
    check("lower_wrap_once", 32'(wrap_out), 32'd0);

    // scan_last 0, dwell 0: pinned at 0, wraps on every advance
    scan_last_in = 3'd0; dwell_in = 8'd0;
    step(); step();
    check("last0_idx", 32'(idx_out), 32'd0);
    check("last0_wrap", 32'(wrap_out), 32'd1);

    // Async reset mid-scan
    scan_last_in = 3'd7;
    step(); step(); step();
    #1 rst_n_in = 1'b0;
    #1;
    check("arst_y", 32'(y_out), 32'(Y_OFF));
    check("arst_idx", 32'(idx_out), 32'd0);
    check("arst_valid", 32'(valid_out), 32'd0);
    step();
    rst_n_in = 1'b1;
    step();
    check("post_rst_idx", 32'(idx_out), 32'd0);
    check("post_rst_y", 32'(y_out), 32'(Y_SEL0));
    step();
    check("post_rst_adv", 32'(idx_out), 32'd1);

    // SCAN -> DIRECT keeps idx; load with simultaneous SCAN entry is ignored
    mode_in = 0;
    step();
    check("s2d_idx", 32'(idx_out), 32'd1);
    check("s2d_y", 32'(y_out), 32'(Y_SEL1));
    mode_in = 1; load_in = 1; sel_in = 3'd6;
    step();
    check("load_vs_scan_idx", 32'(idx_out), 32'd0);
    check("load_vs_scan_wrap", 32'(wrap_out), 32'd0);
    load_in = 0;
    step();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_onehot_seq.md
# decoder_onehot_seq

Registered, parametrised one-hot decoder with two operating modes: direct decode of a loaded select value, and auto-scan that steps the active output through indices 0..scan_last_in with a programmable dwell per position. It is the sequential successor to the team's combinational active-high decoder. Typical uses are multiplexed display digit strobes, round-robin enable generation and bank selects. All outputs are registered, so downstream logic sees glitch-free one-hot strobes.

## Interface
- SEL_WIDTH, 3, index width; output width OUT_WIDTH = 2**SEL_WIDTH (derived, not overridable)
- DWELL_WIDTH, 8, width of dwell_in and the internal dwell counter
- clk_in  input  1  clock, rising edge
- rst_n_in  input  1  one clock; reset is asynchronous and active-low
- enable_in  input  1  1 = decoder active; 0 = all outputs inactive
- mode_in  input  1  0 = DIRECT, 1 = SCAN
- load_in  input  1  DIRECT mode: capture sel_in this cycle
- sel_in  input  SEL_WIDTH  index to decode in DIRECT mode
- dwell_in  input  DWELL_WIDTH  SCAN mode: each position is held dwell_in+1 cycles
- scan_last_in  input  SEL_WIDTH  SCAN mode: last index before wrap to 0
- y_out  output  OUT_WIDTH  one-hot strobe; bit idx_out active when valid_out=1
- idx_out  output  SEL_WIDTH  current index register
- valid_out  output  1  1 when a y_out bit is active
- wrap_out  output  1  one-cycle pulse when SCAN wraps from scan_last_in to 0

## Operation
- States: IDLE, DIRECT, SCAN. The next state is evaluated every edge: enable_in=0 -> IDLE; enable_in=1, mode_in=0 -> DIRECT; enable_in=1, mode_in=1 -> SCAN.
- IDLE:
  - y_out is all inactive and valid_out=0.
  - idx_out retains its value.
  - The dwell counter is cleared.
- DIRECT:
  - load_in=1 -> idx <= sel_in.
  - load_in=0 -> idx holds.
  - This covers entry from IDLE and from SCAN: the retained idx is decoded unless load_in is set in the same cycle.
- SCAN, entry from IDLE or DIRECT:
  - idx <= 0 and the dwell counter <= 0.
  - load_in is ignored.
- SCAN, steady state:
  - The dwell counter increments each cycle.
  - When the counter equals dwell_in, the counter clears and idx advances.
  - Advance rule: if idx >= scan_last_in then idx <= 0 and wrap_out pulses; otherwise idx <= idx+1.
  - The >= comparison handles scan_last_in being lowered below the current idx: the next advance wraps.
- dwell_in and scan_last_in are sampled live every cycle and need no quiescing.
- scan_last_in=0 -> idx stays at 0, and wrap_out pulses on every advance.
- Output mapping: y_out <= (next state != IDLE) ? (1 << next idx) : 0. Polarity is set by Configuration. valid_out <= (next state != IDLE).
- No arithmetic overflow: idx wraps explicitly, and the counter never exceeds dwell_in.

## Timing
- Reset (rst_n_in low, asynchronous):
  - state=IDLE, idx_out=0, dwell counter=0.
  - valid_out=0, wrap_out=0.
  - y_out is all inactive: all 0, or all 1 with the active-low build.
- Release is synchronous to the next rising edge. Reset asserted mid-scan aborts immediately, and the block restarts in IDLE.
- DIRECT latency is one cycle: load_in sampled at edge k gives y_out/idx_out updated after edge k.
- Enable latency is one cycle in both directions (enable_in low at edge k gives y_out inactive after edge k).
- SCAN entry: idx=0 is visible one cycle after the first edge with mode_in=1. Each index is held exactly dwell_in+1 cycles.
- wrap_out is high for exactly the one cycle in which idx_out first shows 0 after a wrap. It never fires on SCAN entry.
- A simultaneous load_in=1 and mode switch to SCAN is resolved as a SCAN entry (load ignored).

## Configuration
- DECODER_ACTIVE_LOW_OUT_EN:
  - Defined: y_out is active-low. The active bit is 0, all other bits are 1, and the inactive/reset value is all 1s.
  - Undefined: y_out is active-high. The active bit is 1 and the inactive/reset value is all 0s.
- idx_out, valid_out and wrap_out are unaffected by the macro.

## Test plan
- Reset and direct load: assert rst_n_in=0, then release; enable_in=1, mode_in=0, load_in=1, sel_in=5 -> one cycle later y_out=8'b0010_0000, idx_out=5, valid_out=1.
- Enable drop: in DIRECT with idx=5, set enable_in=0 -> next cycle y_out=0, valid_out=0, idx_out=5; set enable_in=1 -> y_out=8'b0010_0000 again.
- Scan with dwell: mode_in=1, dwell_in=2, scan_last_in=3 -> idx sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. wrap_out is high only on the cycle idx returns to 0.
- Scan limit lowered mid-run: scanning at idx=6 with scan_last_in=7, change scan_last_in to 2 -> next advance gives idx=0 with a wrap_out pulse.
- Async reset mid-scan: pull rst_n_in low between edges -> y_out=0 and idx_out=0 immediately, without waiting for an edge. After release with enable_in=1, mode_in=1, the scan restarts at idx=0.
- Active-low build with DECODER_ACTIVE_LOW_OUT_EN defined: repeat the first scenario -> y_out=8'b1101_1111; reset value is 8'hFF.
